data_sram_resp: RTL

Data-side memory responder for the pipelined MIPS core: the slave end of the core's MEM-stage data interface (enable, 4-bit byte write mask, byte address, lane-aligned write data, read data). It holds a word-organised on-chip data RAM, services one request at a time with a programmable number of wait states, and stalls the pipeline until each access completes. Sub-word lane alignment and misalignment exceptions are handled upstream. This block only decodes range and applies byte enables.

---
 rtl/data_sram_resp.sv | 95 +++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// Word-organised data RAM responder for the MEM-stage port: one access in flight, WAIT_CYCLES+3 cycles per request.
// Holds the pipeline (mem_stall) until DONE; dropping mem_en in BUSY aborts with no side effect.
module data_sram_resp #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  state_t                stateNext;
  logic [3:0]            cnt;
  logic [31:2]           addrQ;
  logic [3:0]            wenQ;
  logic [31:0]           wdataQ;
  logic                  errFlag;
  logic [DEPTH_LOG2-1:0] wordIdx;
  logic                  inRange;
  logic                  access;
  logic                  unusedLowAddr;

  logic [31:0] ram [0:(1<<DEPTH_LOG2)-1];

  // Byte offset is meaningless here; lane alignment happens upstream.
  assign unusedLowAddr = ^mem_addr[1:0];

  assign wordIdx = addrQ[DEPTH_LOG2+1:2];
  assign inRange = (addrQ[31:DEPTH_LOG2+2] == '0);
  // mem_en is sampled live so an abort on the final BUSY cycle still suppresses the access.
  assign access  = (state == BUSY) && mem_en && (cnt == 4'd0);

  assign mem_stall = mem_en && (state != DONE);
  assign mem_err   = (state == DONE) && errFlag;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (mem_en) stateNext = BUSY;
      BUSY: begin
        if (!mem_en)          stateNext = IDLE;
        else if (cnt == 4'd0) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addrQ     <= '0;
      wenQ      <= 4'd0;
      wdataQ    <= 32'd0;
      mem_rdata <= 32'd0;
      errFlag   <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && mem_en) begin
        addrQ  <= mem_addr[31:2];
        wenQ   <= mem_wen;
        wdataQ <= mem_wdata;
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == BUSY && mem_en && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        if (!inRange)           mem_rdata <= 32'd0;
        else if (wenQ == 4'd0)  mem_rdata <= ram[wordIdx];
      end
      if (state == DONE)               errFlag <= 1'b0;
      else if (access && !inRange)     errFlag <= 1'b1;
    end
  end

  // No reset on the array; an async reset drops state out of BUSY, so a pending write never lands.
  always_ff @(posedge clk) begin
    if (access && inRange) begin
      for (int i = 0; i < 4; i++) begin
        if (wenQ[i]) ram[wordIdx][8*i +: 8] <= wdataQ[8*i +: 8];
      end
    end
  end

endmodule
